// File: rtl/ifetch_queue_if.sv
// ifetch_queue bus bundle: icache request/response, redirect and decode handshake.
// master = the fetch queue, slave = the surrounding core/icache environment.
interface ifetch_queue_if #(
    parameter int XLEN = 32
) ();
    logic [XLEN-1:0] reset_adr_i;
    logic            icache_req_v_o;
    logic [XLEN-1:0] icache_adr_o;
    logic            icache_req_rdy_i;
    logic            icache_rsp_v_i;
    logic [31:0]     icache_instr_i;
    logic            flush_v_q_i;
    logic [XLEN-1:0] pc_data_q_i;
    logic            instr_v_o;
    logic [31:0]     instr_o;
    logic [XLEN-1:0] pc_o;
    logic            dec_rdy_i;

    modport master (
        input  reset_adr_i,
        output icache_req_v_o,
        output icache_adr_o,
        input  icache_req_rdy_i,
        input  icache_rsp_v_i,
        input  icache_instr_i,
        input  flush_v_q_i,
        input  pc_data_q_i,
        output instr_v_o,
        output instr_o,
        output pc_o,
        input  dec_rdy_i
    );

    modport slave (
        output reset_adr_i,
        input  icache_req_v_o,
        input  icache_adr_o,
        output icache_req_rdy_i,
        output icache_rsp_v_i,
        output icache_instr_i,
        output flush_v_q_i,
        output pc_data_q_i,
        input  instr_v_o,
        input  instr_o,
        input  pc_o,
        output dec_rdy_i
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: credit-limited icache requests, in-order responses, flush drop.
// Optional macro IFETCH_QUEUE_BYPASS_EN: present a response combinationally when queue empty.
module ifetch_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    ifetch_queue_if.master bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    // fetch PC
    logic [XLEN-1:0] fpc_q, fpc_d;

    // pending-PC FIFO, one entry per outstanding request
    logic [XLEN-1:0] pend_mem_q [DEPTH];
    logic [XLEN-1:0] pend_mem_d [DEPTH];
    logic [AW-1:0]   pend_rd_q, pend_rd_d;
    logic [AW-1:0]   pend_wr_q, pend_wr_d;
    logic [CW-1:0]   out_q, out_d;

    // responses still owed by the icache for requests killed by a flush
    logic [15:0]     drop_q, drop_d;

    // instruction queue
    entry_t          q_mem_q [DEPTH];
    entry_t          q_mem_d [DEPTH];
    logic [AW-1:0]   q_rd_q, q_rd_d;
    logic [AW-1:0]   q_wr_q, q_wr_d;
    logic [CW-1:0]   q_cnt_q, q_cnt_d;

    logic [CW:0]     inflight;
    logic            credit_ok;
    logic            req_v;
    logic            req_fire;
    logic            rsp_take;
    logic            rsp_drop;
    logic            q_empty;
    logic            byp;
    logic            q_push;
    logic            q_pop;
    logic [XLEN-1:0] pend_head;
    entry_t          q_head;
    logic            flush;

    assign flush     = bus.flush_v_q_i;
    assign pend_head = pend_mem_q[pend_rd_q];
    assign q_head    = q_mem_q[q_rd_q];
    assign q_empty   = (q_cnt_q == '0);

    // Handshake decode: credit check, response classification, bypass and queue moves.
    always_comb begin
        inflight  = {1'b0, q_cnt_q} + {1'b0, out_q};
        credit_ok = (inflight < DEPTH_C);
        req_v     = reset_n & ~flush & credit_ok;
        req_fire  = req_v & bus.icache_req_rdy_i;
        rsp_drop  = bus.icache_rsp_v_i & (flush | (drop_q != '0));
        rsp_take  = bus.icache_rsp_v_i & ~flush & (drop_q == '0) & (out_q != '0);
`ifdef IFETCH_QUEUE_BYPASS_EN
        byp       = q_empty & rsp_take;
`else
        byp       = 1'b0;
`endif
        q_pop     = ~q_empty & bus.dec_rdy_i & ~flush;
        q_push    = rsp_take & ~(byp & bus.dec_rdy_i);
    end

    // Outputs to icache and decode; the queue head wins over a bypassed response.
    always_comb begin
        bus.icache_req_v_o = req_v;
        bus.icache_adr_o   = fpc_q;
        bus.instr_v_o      = ~q_empty | byp;
        bus.instr_o        = '0;
        bus.pc_o           = '0;
        if (!q_empty) begin
            bus.instr_o = q_head.instr;
            bus.pc_o    = q_head.pc;
        end else if (byp) begin
            bus.instr_o = bus.icache_instr_i;
            bus.pc_o    = pend_head;
        end
    end

    // Fetch PC, pending FIFO, outstanding and drop counters.
    always_comb begin
        fpc_d      = fpc_q;
        pend_mem_d = pend_mem_q;
        pend_rd_d  = pend_rd_q;
        pend_wr_d  = pend_wr_q;
        out_d      = out_q;
        drop_d     = drop_q;
        if (flush) begin
            fpc_d     = bus.pc_data_q_i;
            pend_rd_d = '0;
            pend_wr_d = '0;
            out_d     = '0;
            // a response landing in the flush cycle belongs to the killed set
            drop_d    = drop_q + 16'(out_q)
                      - 16'(bus.icache_rsp_v_i
                            && ((drop_q != '0) || (out_q != '0)));
        end else begin
            if (req_fire) begin
                fpc_d                 = fpc_q + XLEN'(4);
                pend_mem_d[pend_wr_q] = fpc_q;
                pend_wr_d             = pend_wr_q + AW'(1);
            end
            if (rsp_take) begin
                pend_rd_d = pend_rd_q + AW'(1);
            end
            out_d = out_q + CW'(req_fire) - CW'(rsp_take);
            if (rsp_drop) begin
                drop_d = drop_q - 16'd1;
            end
        end
    end

    // Instruction queue: push accepted responses, pop on decode consume, clear on flush.
    always_comb begin
        q_mem_d = q_mem_q;
        q_rd_d  = q_rd_q;
        q_wr_d  = q_wr_q;
        q_cnt_d = q_cnt_q;
        if (flush) begin
            q_rd_d  = '0;
            q_wr_d  = '0;
            q_cnt_d = '0;
        end else begin
            if (q_push) begin
                q_mem_d[q_wr_q].instr = bus.icache_instr_i;
                q_mem_d[q_wr_q].pc    = pend_head;
                q_wr_d                = q_wr_q + AW'(1);
            end
            if (q_pop) begin
                q_rd_d = q_rd_q + AW'(1);
            end
            q_cnt_d = q_cnt_q + CW'(q_push) - CW'(q_pop);
        end
    end

    // State registers; reset loads the boot PC and discards all in-flight work.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fpc_q     <= bus.reset_adr_i;
            pend_rd_q <= '0;
            pend_wr_q <= '0;
            out_q     <= '0;
            drop_q    <= '0;
            q_rd_q    <= '0;
            q_wr_q    <= '0;
            q_cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pend_mem_q[i] <= '0;
                q_mem_q[i]    <= '0;
            end
        end else begin
            fpc_q      <= fpc_d;
            pend_mem_q <= pend_mem_d;
            pend_rd_q  <= pend_rd_d;
            pend_wr_q  <= pend_wr_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            q_mem_q    <= q_mem_d;
            q_rd_q     <= q_rd_d;
            q_wr_q     <= q_wr_d;
            q_cnt_q    <= q_cnt_d;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Testbench for ifetch_queue: icache model, scoreboard of expected {pc, instr} in decode order.
// Directed phases: reset, backpressure, push/pop at full, flush drop, wrap, mid-run reset.
module tb_ifetch_queue;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ifetch_queue_if #(.XLEN(32)) bus ();

    ifetch_queue #(.XLEN(32), .DEPTH(4)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int          consumed = 0;
    exp_t        exp_q[$];
    logic [31:0] ic_fifo[$];
    bit          rsp_en = 1'b1;

    function automatic logic [31:0] f_instr(input logic [31:0] a);
        return a ^ 32'h8000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic expect_seq(input logic [31:0] base, input int n);
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            e.pc    = base + 32'(4 * i);
            e.instr = f_instr(e.pc);
            exp_q.push_back(e);
        end
    endtask

    // icache model: in-order, one-cycle response latency, stall via rsp_en
    initial begin : icache_model
        bit          acc;
        bit          fire;
        logic [31:0] acc_adr;
        bus.icache_rsp_v_i = 1'b0;
        bus.icache_instr_i = '0;
        forever begin
            @(negedge clk);
            acc     = reset_n && bus.icache_req_v_o && bus.icache_req_rdy_i;
            acc_adr = bus.icache_adr_o;
            fire    = reset_n && bus.icache_rsp_v_i;
            @(posedge clk);
            #1;
            if (!reset_n) begin
                ic_fifo.delete();
            end else begin
                if (fire && ic_fifo.size() > 0) void'(ic_fifo.pop_front());
                if (acc) ic_fifo.push_back(acc_adr);
            end
            if (reset_n && rsp_en && ic_fifo.size() > 0) begin
                bus.icache_rsp_v_i = 1'b1;
                bus.icache_instr_i = f_instr(ic_fifo[0]);
            end else begin
                bus.icache_rsp_v_i = 1'b0;
                bus.icache_instr_i = '0;
            end
        end
    end

    // scoreboard monitor: compare every consumed instruction against the expected order
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && bus.instr_v_o && bus.dec_rdy_i && !bus.flush_v_q_i) begin
                consumed++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_unexpected: got pc %h, want nothing", bus.pc_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_pc", bus.pc_o, e.pc);
                    chk("mon_instr", bus.instr_o, e.instr);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit found;
        int base;
        bus.reset_adr_i      = 32'h8000_0000;
        bus.icache_req_rdy_i = 1'b1;
        bus.flush_v_q_i      = 1'b0;
        bus.pc_data_q_i      = '0;
        bus.dec_rdy_i        = 1'b0;
        reset_n              = 1'b0;
        expect_seq(32'h8000_0000, 40);

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_v", 32'(bus.icache_req_v_o), 32'd0);
        chk("rst_instr_v", 32'(bus.instr_v_o), 32'd0);
        chk("rst_instr", bus.instr_o, 32'd0);
        chk("rst_pc", bus.pc_o, 32'd0);
        chk("rst_adr", bus.icache_adr_o, 32'h8000_0000);

        // first requests after reset, decode stalled
        tick;
        reset_n = 1'b1;
        @(negedge clk);
        chk("c1_req_v", 32'(bus.icache_req_v_o), 32'd1);
        chk("c1_adr", bus.icache_adr_o, 32'h8000_0000);
        tick;
        @(negedge clk);
        chk("c2_adr", bus.icache_adr_o, 32'h8000_0004);
`ifdef IFETCH_QUEUE_BYPASS_EN
        chk("bypass_same_cycle_v", 32'(bus.instr_v_o), 32'd1);
        chk("bypass_same_cycle_instr", bus.instr_o, 32'h0000_0013);
`else
        chk("nobypass_c2_v", 32'(bus.instr_v_o), 32'd0);
`endif
        tick;
        @(negedge clk);
        chk("c3_adr", bus.icache_adr_o, 32'h8000_0008);
        chk("c3_instr_v", 32'(bus.instr_v_o), 32'd1);
        chk("c3_pc", bus.pc_o, 32'h8000_0000);
        chk("c3_instr", bus.instr_o, 32'h0000_0013);
        tick;
        @(negedge clk);
        chk("c4_req_v", 32'(bus.icache_req_v_o), 32'd1);
        chk("c4_adr", bus.icache_adr_o, 32'h8000_000C);
        for (int i = 0; i < 8; i++) begin
            tick;
            @(negedge clk);
            chk("bp_req_off", 32'(bus.icache_req_v_o), 32'd0);
        end
        chk("bp_head_pc", bus.pc_o, 32'h8000_0000);
        chk("bp_head_instr", bus.instr_o, 32'h0000_0013);

        // push/pop at a full queue with decode toggling
        for (int i = 0; i < 20; i++) begin
            tick;
            bus.dec_rdy_i = i[0];
        end

        // drain, then leave exactly two requests outstanding and flush
        tick;
        chk("toggle_consumed", 32'(consumed), 32'd10);
        bus.dec_rdy_i        = 1'b1;
        bus.icache_req_rdy_i = 1'b0;
        repeat (10) tick;
        @(negedge clk);
        chk("drain_empty", 32'(bus.instr_v_o), 32'd0);
        tick;
        bus.icache_req_rdy_i = 1'b1;
        rsp_en               = 1'b0;
        @(negedge clk);
        chk("out1_req_v", 32'(bus.icache_req_v_o), 32'd1);
        tick;
        @(negedge clk);
        chk("out2_req_v", 32'(bus.icache_req_v_o), 32'd1);
        tick;
        bus.icache_req_rdy_i = 1'b0;
        bus.flush_v_q_i      = 1'b1;
        bus.pc_data_q_i      = 32'h0000_0100;
        rsp_en               = 1'b1;
        expect_seq(32'h0000_0100, 16);
        @(negedge clk);
        chk("flush_req_off", 32'(bus.icache_req_v_o), 32'd0);
        tick;
        bus.flush_v_q_i      = 1'b0;
        bus.icache_req_rdy_i = 1'b1;
        @(negedge clk);
        chk("flush_req_v", 32'(bus.icache_req_v_o), 32'd1);
        chk("flush_adr", bus.icache_adr_o, 32'h0000_0100);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick;
            @(negedge clk);
            if (bus.instr_v_o) found = 1'b1;
        end
        chk("flush_first_seen", 32'(found), 32'd1);
        chk("flush_first_pc", bus.pc_o, 32'h0000_0100);
        chk("flush_first_instr", bus.instr_o, 32'h8000_0113);
        repeat (3) tick;

        // address wrap
        tick;
        bus.flush_v_q_i = 1'b1;
        bus.pc_data_q_i = 32'hFFFF_FFFC;
        expect_seq(32'hFFFF_FFFC, 16);
        @(negedge clk);
        chk("wrap_flush_req_off", 32'(bus.icache_req_v_o), 32'd0);
        tick;
        bus.flush_v_q_i = 1'b0;
        @(negedge clk);
        chk("wrap_adr0", bus.icache_adr_o, 32'hFFFF_FFFC);
        tick;
        @(negedge clk);
        chk("wrap_adr1", bus.icache_adr_o, 32'h0000_0000);
        tick;
        base  = consumed;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick;
            if (consumed >= base + 3) found = 1'b1;
        end
        chk("wrap_consumed", 32'(found), 32'd1);

        // reset in the middle of traffic
        tick;
        reset_n         = 1'b0;
        bus.reset_adr_i = 32'h0000_2000;
        exp_q.delete();
        @(negedge clk);
        chk("mrst_req_v", 32'(bus.icache_req_v_o), 32'd0);
        chk("mrst_instr_v", 32'(bus.instr_v_o), 32'd0);
        chk("mrst_instr", bus.instr_o, 32'd0);
        chk("mrst_pc", bus.pc_o, 32'd0);
        chk("mrst_adr", bus.icache_adr_o, 32'h0000_2000);
        tick;
        tick;
        reset_n = 1'b1;
        expect_seq(32'h0000_2000, 16);
        @(negedge clk);
        chk("mrst_first_req", 32'(bus.icache_req_v_o), 32'd1);
        chk("mrst_first_adr", bus.icache_adr_o, 32'h0000_2000);
        tick;
        base  = consumed;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick;
            if (consumed >= base + 3) found = 1'b1;
        end
        chk("mrst_consumed", 32'(found), 32'd1);
        bus.dec_rdy_i = 1'b0;
        repeat (3) tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning width of address and PC.
REQ-002 SHALL have parameter DEPTH, default 4, meaning instruction-queue entries and the maximum number of outstanding icache requests (power of 2, >=2).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, meaning the reset; it is asynchronous and active-low.
REQ-005 SHALL have port reset_adr_i, input, XLEN, meaning the boot PC, sampled while reset_n=0.
REQ-006 SHALL have port icache_req_v_o, output, 1, meaning a fetch request is valid.
REQ-007 SHALL have port icache_adr_o, output, XLEN, meaning the fetch address.
REQ-008 SHALL have port icache_req_rdy_i, input, 1, meaning the icache accepts the request this cycle.
REQ-009 SHALL have port icache_rsp_v_i, input, 1, meaning an in-order response is valid.
REQ-010 SHALL have port icache_instr_i, input, 32, meaning the response instruction.
REQ-011 SHALL have port flush_v_q_i, input, 1, meaning a redirect from exe.
REQ-012 SHALL have port pc_data_q_i, input, XLEN, meaning the redirect target.
REQ-013 SHALL have port instr_v_o, output, 1, meaning an instruction is presented to dec.
REQ-014 SHALL have port instr_o, output, 32, meaning the presented instruction.
REQ-015 SHALL have port pc_o, output, XLEN, meaning the PC of instr_o.
REQ-016 SHALL have port dec_rdy_i, input, 1, meaning dec consumes the presented instruction.

Function
REQ-017 SHALL hold fetch PC fpc; icache_adr_o=fpc; icache_req_v_o=1 when not flushing and queue_count+outstanding<DEPTH.
REQ-018 SHALL accept a request on icache_req_v_o&icache_req_rdy_i: push fpc into a pending-PC FIFO, outstanding+1, fpc+=4 (mod 2^XLEN, wrap silently).
REQ-019 SHALL, on icache_rsp_v_i with drop_cnt=0, pop the pending PC and push {icache_instr_i, PC} into the instruction queue; outstanding-1.
REQ-020 SHALL, on icache_rsp_v_i with drop_cnt>0, discard the response and decrement drop_cnt; queue unchanged.
REQ-021 SHALL present the queue head: instr_v_o=queue not empty; instr_o/pc_o=head entry; pop on instr_v_o&dec_rdy_i.
REQ-022 SHALL allow push and pop in the same cycle; count unchanged; queue never overflows, because the credit rule REQ-017 prevents it.
REQ-023 SHALL, on flush_v_q_i=1: set fpc<=pc_data_q_i, empty the queue, clear the pending FIFO, and set drop_cnt<=drop_cnt+outstanding minus any same-cycle response; outstanding<=0; icache_req_v_o=0 that cycle.
REQ-024 SHALL drop a response arriving in the flush cycle, and SHALL ignore dec_rdy_i in that cycle.
REQ-025 SHALL, on response with both pending FIFO empty and drop_cnt=0, ignore it (protocol error, no state change).
REQ-026 SHALL fetch at least one instruction per cycle at steady state with single-cycle icache, never duplicate or reorder instructions, and never present a pre-flush instruction after the flush cycle.

Reset
REQ-027 SHALL, while reset_n=0: fpc=reset_adr_i, queue/pending empty, outstanding=0, drop_cnt=0, icache_req_v_o=0, instr_v_o=0, instr_o=0, pc_o=0.
REQ-028 SHALL issue the first request at reset_adr_i in the first cycle after reset_n rises; reset mid-transaction discards all in-flight state.

Configuration
REQ-029 SHALL support macro IFETCH_QUEUE_BYPASS_EN; defined: when queue empty and an accepted response arrives, instr_o/pc_o/instr_v_o SHALL show it combinationally the same cycle, and SHALL not enqueue it if dec_rdy_i=1; undefined: responses always enqueue first, response-to-instr_v_o latency 1 cycle.

Verification
REQ-030 SHALL cover reset: reset_adr_i=0x8000_0000 -> first icache_adr_o=0x8000_0000, then 0x8000_0004, 0x8000_0008 in consecutive cycles with rdy=1, rsp 1 cycle later.
REQ-031 SHALL cover backpressure: dec_rdy_i=0, DEPTH=4 -> exactly 4 requests issued, icache_req_v_o=0 thereafter, instr_o stays first instruction at 0x8000_0000.
REQ-032 SHALL cover flush with 2 outstanding: flush_v_q_i=1, pc_data_q_i=0x100 -> next request adr 0x100, two following responses dropped, first instr_v_o has pc_o=0x100.
REQ-033 SHALL cover simultaneous push/pop at full queue: DEPTH=4, dec_rdy_i toggled -> count stays at most 4, order preserved, no lost PC.
REQ-034 SHALL cover wrap: fpc=0xFFFF_FFFC -> next adr 0x0000_0000.
REQ-035 SHALL cover bypass: IFETCH_QUEUE_BYPASS_EN defined, empty queue, response 0x0000_0013 -> instr_v_o=1 same cycle; macro undefined -> next cycle.
